// File: rtl/io_reg_pkg.sv
// Shared types and helpers for the IO input filter stage.
// IN_FILT_SYNC_EN (optional) adds a two-flop synchroniser ahead of the sample register.
package io_reg_pkg;

    typedef enum logic [1:0] {
        S_LO = 2'd0,
        P_HI = 2'd1,
        S_HI = 2'd2,
        P_LO = 2'd3
    } filt_state_e;

    localparam int unsigned FILT_CYCLES_DEF = 4;
    localparam int unsigned CNT_W_DEF       = 8;

    // Debounce counter must hold up to FILT_CYCLES-1.
    function automatic int unsigned dcnt_width(input int unsigned filt_cycles);
        return (filt_cycles < 2) ? 1 : $clog2(filt_cycles);
    endfunction

    localparam int unsigned DCNT_W = dcnt_width(FILT_CYCLES_DEF);

    // Saturation value of a CNT_W-bit event counter.
    function automatic logic [15:0] sat_val(input int unsigned cnt_w);
        return 16'((32'd1 << cnt_w) - 32'd1);
    endfunction

endpackage

// File: rtl/in_filt_cell_if.sv
// Fabric-facing bundle of the input filter cell: level in, enable/ack in, filtered status out.
interface in_filt_cell_if #(
    parameter int unsigned CNT_W = 8
);
    logic             IQZ_IN;
    logic             EN;
    logic             ACK;
    logic             FILT_Q;
    logic             RISE;
    logic             FALL;
    logic             EVT_VALID;
    logic [CNT_W-1:0] EVT_CNT;
    logic             OVF;

    modport master (
        output IQZ_IN, EN, ACK,
        input  FILT_Q, RISE, FALL, EVT_VALID, EVT_CNT, OVF
    );

    modport slave (
        input  IQZ_IN, EN, ACK,
        output FILT_Q, RISE, FALL, EVT_VALID, EVT_CNT, OVF
    );
endinterface

// File: rtl/in_filt_fsm.sv
// Sample/sync flops plus the debounce FSM producing the filtered level and edge pulses.
// With IN_FILT_SYNC_EN defined, two synchroniser flops precede the sample register.
module in_filt_fsm
    import io_reg_pkg::*;
#(
    parameter int unsigned FILT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic iqz,
    input  logic en,
    output logic filt_q,
    output logic rise,
    output logic fall,
    output logic edge_c
);
    localparam int unsigned   DW        = dcnt_width(FILT_CYCLES);
    localparam logic [DW-1:0] DCNT_LAST = DW'(FILT_CYCLES - 1);

    logic          smp;
    filt_state_e   state, state_nxt;
    logic [DW-1:0] dcnt, dcnt_nxt;
    logic          rise_nxt, fall_nxt;

`ifdef IN_FILT_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b00;
            smp  <= 1'b0;
        end else begin
            sync <= {sync[0], iqz};
            smp  <= sync[1];
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) smp <= 1'b0;
        else     smp <= iqz;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_LO;
            dcnt   <= '0;
            filt_q <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            state  <= state_nxt;
            dcnt   <= dcnt_nxt;
            filt_q <= (state_nxt == S_HI) || (state_nxt == P_LO);
            rise   <= rise_nxt;
            fall   <= fall_nxt;
        end
    end

    // Pending states abort on a reverted sample or a dropped enable.
    always_comb begin
        state_nxt = state;
        dcnt_nxt  = dcnt;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            S_LO: begin
                if (smp && en) begin
                    state_nxt = P_HI;
                    dcnt_nxt  = DW'(1);
                end
            end
            P_HI: begin
                if (!en || !smp) begin
                    state_nxt = S_LO;
                    dcnt_nxt  = '0;
                end else if (dcnt == DCNT_LAST) begin
                    state_nxt = S_HI;
                    dcnt_nxt  = '0;
                    rise_nxt  = 1'b1;
                end else begin
                    dcnt_nxt  = dcnt + DW'(1);
                end
            end
            S_HI: begin
                if (!smp && en) begin
                    state_nxt = P_LO;
                    dcnt_nxt  = DW'(1);
                end
            end
            P_LO: begin
                if (!en || smp) begin
                    state_nxt = S_HI;
                    dcnt_nxt  = '0;
                end else if (dcnt == DCNT_LAST) begin
                    state_nxt = S_LO;
                    dcnt_nxt  = '0;
                    fall_nxt  = 1'b1;
                end else begin
                    dcnt_nxt  = dcnt + DW'(1);
                end
            end
            default: begin
                state_nxt = S_LO;
                dcnt_nxt  = '0;
            end
        endcase
    end

    assign edge_c = rise_nxt | fall_nxt;

endmodule

// File: rtl/in_filt_cell.sv
// Input filter cell: debounced level, edge pulses and a saturating edge counter read via VALID/ACK.
// Build option IN_FILT_SYNC_EN inserts a two-flop synchroniser (adds 2 cycles of latency).
module in_filt_cell
    import io_reg_pkg::*;
#(
    parameter int unsigned FILT_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input logic           IQC,
    input logic           QRT,
    in_filt_cell_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(sat_val(CNT_W));

    logic             filt_q, rise, fall, edge_c;
    logic [CNT_W-1:0] evt_cnt, evt_cnt_nxt;
    logic             ovf, ovf_nxt;
    logic             evt_valid;

    in_filt_fsm #(
        .FILT_CYCLES (FILT_CYCLES)
    ) u_fsm (
        .clk    (IQC),
        .rst    (QRT),
        .iqz    (bus.IQZ_IN),
        .en     (bus.EN),
        .filt_q (filt_q),
        .rise   (rise),
        .fall   (fall),
        .edge_c (edge_c)
    );

    // ACK wins over increment but an edge on the same cycle still counts as one.
    always_comb begin
        evt_cnt_nxt = evt_cnt;
        ovf_nxt     = ovf;
        if (bus.ACK) begin
            evt_cnt_nxt = edge_c ? CNT_W'(1) : '0;
            ovf_nxt     = 1'b0;
        end else if (edge_c) begin
            if (evt_cnt != CNT_SAT) evt_cnt_nxt = evt_cnt + CNT_W'(1);
            else                    ovf_nxt     = 1'b1;
        end
    end

    always_ff @(posedge IQC or posedge QRT) begin
        if (QRT) begin
            evt_cnt   <= '0;
            ovf       <= 1'b0;
            evt_valid <= 1'b0;
        end else begin
            evt_cnt   <= evt_cnt_nxt;
            ovf       <= ovf_nxt;
            evt_valid <= (evt_cnt_nxt != '0);
        end
    end

    assign bus.FILT_Q    = filt_q;
    assign bus.RISE      = rise;
    assign bus.FALL      = fall;
    assign bus.EVT_CNT   = evt_cnt;
    assign bus.EVT_VALID = evt_valid;
    assign bus.OVF       = ovf;

endmodule

// File: tb/tb_in_filt_cell.sv
// Bench for in_filt_cell: two instances (CNT_W=8 and CNT_W=2) against a run-length reference model.
module tb_in_filt_cell;
    localparam int unsigned F = 4;
`ifdef IN_FILT_SYNC_EN
    localparam int unsigned D = 3;
`else
    localparam int unsigned D = 1;
`endif
    localparam int unsigned LAT = F + D;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic iqz = 1'b0;
    logic en  = 1'b0;
    logic ack = 1'b0;
    int   errors = 0;
    int   checks = 0;

    in_filt_cell_if #(.CNT_W(8)) bus_a ();
    in_filt_cell_if #(.CNT_W(2)) bus_b ();

    assign bus_a.IQZ_IN = iqz;
    assign bus_a.EN     = en;
    assign bus_a.ACK    = ack;
    assign bus_b.IQZ_IN = iqz;
    assign bus_b.EN     = en;
    assign bus_b.ACK    = ack;

    in_filt_cell #(.FILT_CYCLES(F), .CNT_W(8)) dut_a (.IQC(clk), .QRT(rst), .bus(bus_a));
    in_filt_cell #(.FILT_CYCLES(F), .CNT_W(2)) dut_b (.IQC(clk), .QRT(rst), .bus(bus_b));

    always #5 clk = ~clk;

    // Reference model: filtered level flips after F consecutive enabled samples that differ from it.
    logic [2:0] m_pipe;
    logic       m_filt, m_rise, m_fall, m_ovf_a, m_ovf_b;
    int         m_run, m_cnt_a, m_cnt_b;

    task automatic m_reset();
        m_pipe = 3'b000; m_filt = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
        m_run = 0; m_cnt_a = 0; m_cnt_b = 0; m_ovf_a = 1'b0; m_ovf_b = 1'b0;
    endtask

    function automatic void cnt_upd(inout int cnt, inout logic ovf, input int sat,
                                    input logic a, input logic ev);
        if (a) begin
            cnt = ev ? 1 : 0;
            ovf = 1'b0;
        end else if (ev) begin
            if (cnt < sat) cnt = cnt + 1;
            else           ovf = 1'b1;
        end
    endfunction

    // One clock: drive inputs, advance DUT and model together, land 1 time unit after the edge.
    task automatic step(input logic i, input logic e, input logic a);
        logic s;
        iqz = i; en = e; ack = a;
        @(posedge clk);
        s = m_pipe[D-1];
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (s != m_filt && e) m_run = m_run + 1;
        else                  m_run = 0;
        if (m_run == int'(F)) begin
            m_filt = ~m_filt;
            m_run  = 0;
            m_rise = m_filt;
            m_fall = ~m_filt;
        end
        cnt_upd(m_cnt_a, m_ovf_a, 255, a, m_rise | m_fall);
        cnt_upd(m_cnt_b, m_ovf_b, 3,   a, m_rise | m_fall);
        m_pipe = {m_pipe[1:0], i};
        #1;
    endtask

    function automatic logic [19:0] exp_vec();
        return {m_filt, m_rise, m_fall, m_cnt_a != 0, 8'(m_cnt_a), m_ovf_a,
                m_filt, m_rise, m_fall, m_cnt_b != 0, 2'(m_cnt_b), m_ovf_b};
    endfunction

    function automatic logic [19:0] obs_vec();
        return {bus_a.FILT_Q, bus_a.RISE, bus_a.FALL, bus_a.EVT_VALID, bus_a.EVT_CNT, bus_a.OVF,
                bus_b.FILT_Q, bus_b.RISE, bus_b.FALL, bus_b.EVT_VALID, bus_b.EVT_CNT, bus_b.OVF};
    endfunction

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs_vec() !== 20'h0) begin
            errors++; $display("FAIL reset_async got=%h exp=%h", obs_vec(), 20'h0);
        end
        #6;
        checks++;
        if (obs_vec() !== 20'h0) begin
            errors++; $display("FAIL reset_held got=%h exp=%h", obs_vec(), 20'h0);
        end
        #3 rst = 1'b0;
        m_reset();
    endtask

    task automatic test_basic_rise();
        int rise_at = 0;
        int rise_n  = 0;
        for (int k = 1; k <= int'(LAT) + 4; k++) begin
            step(1'b1, 1'b1, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL basic_rise step=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            end
            if (bus_a.RISE === 1'b1) begin rise_n++; rise_at = k; end
        end
        checks++;
        if (rise_at != int'(LAT) || rise_n != 1) begin
            errors++; $display("FAIL rise_latency got=%0d/%0d exp=%0d/1", rise_at, rise_n, LAT);
        end
        checks++;
        if (bus_a.EVT_CNT !== 8'd1 || bus_a.EVT_VALID !== 1'b1 || bus_a.FILT_Q !== 1'b1) begin
            errors++; $display("FAIL rise_count got=%0d v=%b q=%b exp=1 v=1 q=1",
                               bus_a.EVT_CNT, bus_a.EVT_VALID, bus_a.FILT_Q);
        end
    endtask

    task automatic test_glitch();
        logic saw = 1'b0;
        for (int k = 0; k < 25; k++) begin
            if (k < 12)      step(1'b0, 1'b1, 1'b0);
            else if (k < 15) step(1'b1, 1'b1, 1'b0);
            else             step(1'b0, 1'b1, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL glitch step=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            end
            if (k >= 12 && bus_a.RISE === 1'b1) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0 || bus_a.FILT_Q !== 1'b0 || bus_a.EVT_CNT !== 8'd2) begin
            errors++; $display("FAIL glitch_reject got rise=%b q=%b cnt=%0d exp rise=0 q=0 cnt=2",
                               saw, bus_a.FILT_Q, bus_a.EVT_CNT);
        end
    endtask

    task automatic test_saturation();
        step(1'b0, 1'b1, 1'b1);
        for (int e = 0; e < 4; e++) begin
            for (int k = 0; k < int'(LAT) + 2; k++) begin
                step((e % 2) == 0, 1'b1, 1'b0);
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    errors++; $display("FAIL sat e=%0d step=%0d got=%h exp=%h", e, k, obs_vec(), exp_vec());
                end
            end
        end
        checks++;
        if (bus_b.EVT_CNT !== 2'd3 || bus_b.OVF !== 1'b1 || bus_a.EVT_CNT !== 8'd4 || bus_a.OVF !== 1'b0) begin
            errors++; $display("FAIL sat_ovf got b=%0d/%b a=%0d/%b exp b=3/1 a=4/0",
                               bus_b.EVT_CNT, bus_b.OVF, bus_a.EVT_CNT, bus_a.OVF);
        end
        step(1'b0, 1'b1, 1'b1);
        checks++;
        if (bus_b.EVT_CNT !== 2'd0 || bus_b.OVF !== 1'b0 || bus_b.EVT_VALID !== 1'b0) begin
            errors++; $display("FAIL sat_ack got cnt=%0d ovf=%b v=%b exp 0 0 0",
                               bus_b.EVT_CNT, bus_b.OVF, bus_b.EVT_VALID);
        end
    endtask

    task automatic test_ack_edge();
        for (int ph = 0; ph < 4; ph++) begin
            for (int k = 0; k < int'(LAT) + 2; k++) begin
                step(ph != 2, 1'b1, (ph == 1) && (k == 0));
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    errors++; $display("FAIL ack_setup ph=%0d step=%0d got=%h exp=%h", ph, k, obs_vec(), exp_vec());
                end
            end
        end
        // Filtered high, count 2: fall the level with ACK on the accepting edge.
        for (int k = 1; k <= int'(LAT); k++) begin
            step(1'b0, 1'b1, k == int'(LAT));
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL ack_edge step=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (bus_a.FALL !== 1'b1 || bus_a.EVT_CNT !== 8'd1 || bus_a.EVT_VALID !== 1'b1 || bus_b.EVT_CNT !== 2'd1) begin
            errors++; $display("FAIL ack_edge_cnt got fall=%b a=%0d v=%b b=%0d exp 1 1 1 1",
                               bus_a.FALL, bus_a.EVT_CNT, bus_a.EVT_VALID, bus_b.EVT_CNT);
        end
        step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_en_abort();
        int fall_at = 0;
        int fall_n  = 0;
        for (int k = 0; k < int'(LAT) + 2; k++) step(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < int'(D) + 2; k++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (bus_a.FILT_Q !== 1'b1 || bus_a.FALL !== 1'b0 || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL en_abort got q=%b fall=%b vec=%h exp q=1 fall=0 vec=%h",
                               bus_a.FILT_Q, bus_a.FALL, obs_vec(), exp_vec());
        end
        for (int k = 1; k <= int'(F) + 2; k++) begin
            step(1'b0, 1'b1, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL en_restart step=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            end
            if (bus_a.FALL === 1'b1) begin fall_n++; fall_at = k; end
        end
        checks++;
        if (fall_at != int'(F) || fall_n != 1) begin
            errors++; $display("FAIL en_restart_lat got=%0d/%0d exp=%0d/1", fall_at, fall_n, F);
        end
    endtask

    task automatic test_async_reset_mid();
        int rise_at = 0;
        for (int k = 0; k < int'(D) + 3; k++) step(1'b1, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs_vec() !== 20'h0) begin
            errors++; $display("FAIL reset_mid got=%h exp=%h", obs_vec(), 20'h0);
        end
        #10 rst = 1'b0;
        m_reset();
        for (int k = 1; k <= int'(LAT) + 2; k++) begin
            step(1'b1, 1'b1, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL post_reset step=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            end
            if (bus_a.RISE === 1'b1 && rise_at == 0) rise_at = k;
        end
        checks++;
        if (rise_at != int'(LAT)) begin
            errors++; $display("FAIL post_reset_lat got=%0d exp=%0d", rise_at, LAT);
        end
    endtask

    task automatic test_random();
        logic lvl  = 1'b0;
        int   hold = 0;
        for (int k = 0; k < 800; k++) begin
            if (hold == 0) begin
                lvl  = ~lvl;
                hold = int'($urandom_range(1, 9));
            end
            hold--;
            step(lvl, $urandom_range(0, 15) != 0, $urandom_range(0, 24) == 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL random step=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_basic_rise();
        test_glitch();
        test_saturation();
        test_ack_edge();
        test_en_abort();
        test_async_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/in_filt_cell.md
Name: in_filt_cell

Overview:
- Fabric-side stage directly downstream of the IO input register cell. It consumes that cell's IQZ output.
- Filters (debounces) the pad-derived level and flags qualified rising/falling edges with one-cycle pulses.
- Accumulates an edge-event count that fabric logic reads and clears through a VALID/ACK handshake.
- Same clock and reset as the input register cell.

Parameters:
- FILT_CYCLES, 4, consecutive samples of a new level required before it is accepted; legal range 2..255.
- CNT_W, 8, width of the event counter; legal range 2..16.

Ports:
- IQC  input  1  clock; same clock as the input register cell.
- QRT  input  1  reset; asynchronous, active-high; clears all state.
- IQZ_IN  input  1  level from the input register cell's IQZ output.
- EN  input  1  filter enable.
- ACK  input  1  fabric acknowledge; clears the event count.
- FILT_Q  output  1  filtered level.
- RISE  output  1  one-cycle pulse on an accepted 0->1 transition.
- FALL  output  1  one-cycle pulse on an accepted 1->0 transition.
- EVT_VALID  output  1  high while EVT_CNT != 0.
- EVT_CNT  output  CNT_W  number of accepted edges since the last ACK; saturating.
- OVF  output  1  sticky; an edge was lost because the counter was saturated.

Behaviour:
- Reset (QRT=1, asynchronous):
  - FSM in S_LO; sample register = 0; debounce count = 0.
  - FILT_Q=0, RISE=0, FALL=0, EVT_CNT=0, EVT_VALID=0, OVF=0.
- Sampling: the sample register smp <= IQZ_IN on every IQC posedge, independent of EN.
- FSM states: S_LO, P_HI (pending high), S_HI, P_LO (pending low). FILT_Q = 1 in S_HI and P_LO, 0 otherwise (registered).
- S_LO:
  - smp=1 and EN=1 -> P_HI, dcnt=1.
  - Otherwise stay.
- P_HI:
  - smp=0 -> S_LO, dcnt=0, no pulse (glitch rejected).
  - smp=1 and dcnt==FILT_CYCLES-1 -> S_HI; RISE=1 for exactly one cycle.
  - smp=1 otherwise -> dcnt+1.
- S_HI and P_LO: mirror of S_LO and P_HI with the levels swapped; the accepting transition pulses FALL.
- Latency: if smp first captures the new level at edge k and holds it, FILT_Q and the pulse change at edge k+FILT_CYCLES, which is FILT_CYCLES+1 edges after IQZ_IN changes.
- EN=0:
  - P_HI aborts to S_LO and P_LO aborts to S_HI, with dcnt=0.
  - Stable states hold; no pulses.
  - Counter and handshake keep operating.
- Event counter, per edge. "Edge" below means a RISE or FALL pulse is being set on that same edge.
  - ACK=1 -> EVT_CNT <= (edge ? 1 : 0); OVF <= 0.
  - ACK=0 with an edge and EVT_CNT < 2^CNT_W-1 -> increment.
  - ACK=0 with an edge and EVT_CNT == 2^CNT_W-1 -> hold and set OVF.
  - ACK and an edge in the same cycle: the count is cleared to 1 and the new edge is never lost.
- EVT_VALID = (EVT_CNT != 0), decoded from the register; no extra latency.
- ACK while EVT_CNT == 0 is harmless; it also clears OVF.
- RISE and FALL are never asserted together.

Optional Feature:
- Macro IN_FILT_SYNC_EN.
- Defined: two additional flops are inserted ahead of smp. They are a metastability synchroniser for configurations where the input register cell is bypassed and IQZ is combinational from the pad. All latencies grow by 2 cycles; both flops reset to 0.
- Undefined: single sample register only; latency as stated above.

Decomposition:
- Shared package io_reg_pkg holds:
  - the FSM state enum (S_LO, P_HI, S_HI, P_LO);
  - the debounce counter width constant, computed as clog2 of FILT_CYCLES;
  - a function giving the saturation value 2^CNT_W-1.
- One natural sub-module, in_filt_fsm, contains the sample/sync flops, the FSM and dcnt, and outputs FILT_Q, RISE and FALL. The event counter and handshake stay in the top level.

Test Plan:
- Reset and basic rise:
  - Stimulus: QRT pulse mid-cycle, then IQZ_IN=1 held from edge 10, FILT_CYCLES=4, EN=1.
  - Response: all outputs 0 during reset; smp=1 at edge 10; FILT_Q=1 and RISE=1 at edge 14 only; EVT_CNT=1; EVT_VALID=1.
- Glitch rejection:
  - Stimulus: IQZ_IN high for exactly 3 samples, FILT_CYCLES=4.
  - Response: FSM returns to S_LO; FILT_Q stays 0; no RISE; EVT_CNT unchanged.
- Saturation and OVF:
  - Stimulus: CNT_W=2, 4 accepted edges without ACK.
  - Response: EVT_CNT=3 and OVF=1 after the 4th edge; then ACK -> EVT_CNT=0, OVF=0, EVT_VALID=0.
- Simultaneous ACK and edge:
  - Stimulus: EVT_CNT=2, ACK asserted on the same edge FALL is set.
  - Response: EVT_CNT=1 and EVT_VALID remains 1.
- EN abort:
  - Stimulus: FSM in P_LO with dcnt=2, drop EN.
  - Response: next edge returns to S_HI; FILT_Q stays 1; no FALL; re-raising EN restarts with dcnt=1.
- Asynchronous reset mid-pending:
  - Stimulus: QRT asserted between edges while in P_HI with dcnt=3.
  - Response: immediate FILT_Q=0, EVT_CNT=0; no RISE after reset release until 4 fresh high samples.
